// File: rtl/au_seq.sv
// rtl/au_seq.sv - sequential arithmetic unit: ADD/ADC/SUB single-cycle, shift-add MUL, valid/ready on both sides
module au_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             O,
  output logic             Z,
  output logic             E,
  output logic             G,
  output logic             L
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  // Last multiplier iteration index; the MUL state lasts exactly WIDTH cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e state_q, state_d;

  // Operands latched at the accept edge; only the compare flags of a MUL need them later.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;

  // Shift-add multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Registered result and flags, held stable through DONE.
  logic [WIDTH-1:0]   s_q, s_d;
  logic               c_q, c_d;
  logic               o_q, o_d;
  logic               z_q, z_d;
  logic               e_q, e_d;
  logic               g_q, g_d;
  logic               l_q, l_d;

  // Persistent carry/borrow consumed by ADC.
  logic               cq_q, cq_d;

  // Single-cycle add/subtract datapath.
  logic               add_cin;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   alu_s;
  logic               alu_c;
  logic               alu_o;

  // Multiplier step and compare datapath.
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   cmp_a;
  logic [WIDTH-1:0]   cmp_b;
  logic               cmp_eq;
  logic               cmp_gt;
  logic               cmp_lt;

  // Add/sub result, carry/borrow and signed overflow for the operands at the input port.
  always_comb begin
    add_cin  = (op == OP_ADC) ? cq_q : 1'b0;
    add_full = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, add_cin};
    sub_full = {1'b0, A} - {1'b0, B};
    alu_s    = add_full[WIDTH-1:0];
    alu_c    = add_full[WIDTH];
    alu_o    = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
    if (op == OP_SUB) begin
      // The extra MSB of the widened difference is the borrow.
      alu_s = sub_full[WIDTH-1:0];
      alu_c = sub_full[WIDTH];
      alu_o = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
    end
  end

  // One shift-add iteration and the unsigned compare of the operands being finished this cycle.
  always_comb begin
    prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    // Single-cycle ops complete at the accept edge, so they compare the live inputs.
    cmp_a  = (state_q == ST_MUL) ? a_q : A;
    cmp_b  = (state_q == ST_MUL) ? b_q : B;
    cmp_eq = (cmp_a == cmp_b);
    cmp_gt = (cmp_a >  cmp_b);
    cmp_lt = (cmp_a <  cmp_b);
  end

  // Next-state and datapath update for the IDLE/MUL/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    c_d      = c_q;
    o_d      = o_q;
    z_d      = z_q;
    e_d      = e_q;
    g_d      = g_q;
    l_d      = l_q;
    cq_d     = cq_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d = A;
          b_d = B;
          if (op == OP_MUL) begin
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            s_d     = alu_s;
            c_d     = alu_c;
            o_d     = alu_o;
            z_d     = (alu_s == '0);
            e_d     = cmp_eq;
            g_d     = cmp_gt;
            l_d     = cmp_lt;
            cq_d    = alu_c;
            state_d = ST_DONE;
          end
        end
      end

      ST_MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Final bit folded in this cycle; publish from the stepped product. cq is left alone.
          s_d     = prod_step[WIDTH-1:0];
          c_d     = |prod_step[2*WIDTH-1:WIDTH];
          o_d     = |prod_step[2*WIDTH-1:WIDTH];
          z_d     = (prod_step[WIDTH-1:0] == '0);
          e_d     = cmp_eq;
          g_d     = cmp_gt;
          l_d     = cmp_lt;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      s_q      <= '0;
      c_q      <= 1'b0;
      o_q      <= 1'b0;
      z_q      <= 1'b0;
      e_q      <= 1'b0;
      g_q      <= 1'b0;
      l_q      <= 1'b0;
      cq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      c_q      <= c_d;
      o_q      <= o_d;
      z_q      <= z_d;
      e_q      <= e_d;
      g_q      <= g_d;
      l_q      <= l_d;
      cq_q     <= cq_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign S         = s_q;
  assign C         = c_q;
  assign O         = o_q;
  assign Z         = z_q;
  assign E         = e_q;
  assign G         = g_q;
  assign L         = l_q;

endmodule

// File: tb/tb_au_seq.sv
// tb/tb_au_seq.sv - directed bench for au_seq with an arithmetic reference model and per-cycle output compare
module tb_au_seq;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         C;
  logic         O;
  logic         Z;
  logic         E;
  logic         G;
  logic         L;

  au_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .C         (C),
    .O         (O),
    .Z         (Z),
    .E         (E),
    .G         (G),
    .L         (L)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    bit c;
    bit o;
    bit z;
    bit e;
    bit g;
    bit l;
  } exp_t;

  exp_t expq[$];
  int   mcq;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic int sgn(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  task automatic model_push(input logic [1:0] o, input int a, input int b);
    exp_t   e;
    longint r;
    int     sr;
    int     cin;
    cin = (o == 2'b01) ? mcq : 0;
    case (o)
      2'b00, 2'b01: begin
        r   = longint'(a) + b + cin;
        e.c = (r >= M);
        sr  = sgn(a) + sgn(b) + cin;
        e.o = (sr >= M / 2) || (sr < -(M / 2));
      end
      2'b10: begin
        r   = longint'(a) - b + M;
        e.c = (a < b);
        sr  = sgn(a) - sgn(b);
        e.o = (sr >= M / 2) || (sr < -(M / 2));
      end
      default: begin
        r   = longint'(a) * b;
        e.c = (r >= M);
        e.o = e.c;
      end
    endcase
    e.s = int'(r % M);
    e.z = (e.s == 0);
    e.e = (a == b);
    e.g = (a > b);
    e.l = (a < b);
    if (o != 2'b11) mcq = e.c ? 1 : 0;
    expq.push_back(e);
  endtask

  // Every cycle a result is presented, it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("mon_S", S, expq[0].s);
        chk("mon_C", C, expq[0].c);
        chk("mon_O", O, expq[0].o);
        chk("mon_Z", Z, expq[0].z);
        chk("mon_E", E, expq[0].e);
        chk("mon_G", G, expq[0].g);
        chk("mon_L", L, expq[0].l);
        chk("mon_EGL_onehot", int'(E) + int'(G) + int'(L), 1);
        if (out_ready) expq.delete(0);
      end
    end
  end

  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int hold, input int exp_s, input bit exp_c, input bit exp_o);
    bit got;
    int lat;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    op        = o;
    A         = a;
    B         = b;
    out_ready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    chk("accept", got, 1);
    if (!got) begin
      in_valid = 1'b0;
      return;
    end
    model_push(o, a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A  = ~a;
    B  = ~b;
    op = ~o;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk("latency", lat, (o == 2'b11) ? W + 1 : 1);
    chk("lit_S", S, exp_s);
    chk("lit_C", C, exp_c);
    chk("lit_O", O, exp_o);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        in_valid = h[0];
        A  = W'($urandom);
        B  = W'($urandom);
        op = 2'($urandom);
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  task automatic reset_mid_mul();
    @(posedge clk); #1;
    in_valid  = 1'b1;
    op        = 2'b11;
    A         = 8'h33;
    B         = 8'h55;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mul_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_S", S, 0);
    chk("async_C", C, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    mcq = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    op        = 2'b00;
    mcq       = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_S", S, 0);
    chk("reset_C", C, 0);
    chk("reset_Z", Z, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    run(2'b00, 8'h1C, 8'h14, 0, 8'h30, 1'b0, 1'b0);
    run(2'b00, 8'h7C, 8'h14, 0, 8'h90, 1'b0, 1'b1);
    run(2'b00, 8'h9C, 8'h94, 0, 8'h30, 1'b1, 1'b1);
    run(2'b01, 8'h01, 8'h01, 0, 8'h03, 1'b0, 1'b0);
    run(2'b10, 8'h1C, 8'h1C, 0, 8'h00, 1'b0, 1'b0);
    run(2'b10, 8'h04, 8'h14, 0, 8'hF0, 1'b1, 1'b0);
    run(2'b11, 8'h04, 8'h14, 0, 8'h50, 1'b0, 1'b0);
    run(2'b11, 8'h20, 8'h10, 0, 8'h00, 1'b1, 1'b1);
    run(2'b01, 8'h00, 8'h00, 0, 8'h01, 1'b0, 1'b0);
    run(2'b00, 8'hFF, 8'h01, 5, 8'h00, 1'b1, 1'b0);
    run(2'b11, 8'hFF, 8'hFF, 2, 8'h01, 1'b1, 1'b1);
    run(2'b11, 8'h00, 8'h37, 0, 8'h00, 1'b0, 1'b0);
    run(2'b01, 8'h7F, 8'h00, 0, 8'h80, 1'b0, 1'b1);
    run(2'b10, 8'h80, 8'h01, 0, 8'h7F, 1'b0, 1'b1);
    run(2'b00, 8'hFF, 8'h02, 0, 8'h01, 1'b1, 1'b0);
    reset_mid_mul();
    run(2'b01, 8'h01, 8'h01, 0, 8'h02, 1'b0, 1'b0);

    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
